// File: rtl/spi_frame_sender.sv
// rtl/spi_frame_sender.sv - SPI master that streams one frame out of a frame RAM
// Pixel 0 first, bit 0 first; one FETCH cycle precedes the first bit of every pixel.
module spi_frame_sender #(
  parameter int CDEPTH   = 4,
  parameter int NPIX     = 1024,
  parameter int SCK_HALF = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic                abort,
  input  logic [3*CDEPTH-1:0] rpix,
  output logic [9:0]          raddr,
  output logic                sck,
  output logic                sdo,
  output logic                cs_n,
  output logic                busy,
  output logic                done
);
  localparam int PW = 3 * CDEPTH;
  localparam int BW = (PW > 1) ? $clog2(PW) : 1;
  localparam int HW = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;
  localparam logic [BW-1:0] LAST_BIT  = BW'(PW - 1);
  localparam logic [HW-1:0] LAST_HALF = HW'(SCK_HALF - 1);
  localparam logic [9:0]    LAST_PIX  = 10'(NPIX - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LOW, S_HIGH, S_FINISH} state_t;

  state_t        r_state;
  logic [PW-1:0] r_shift;
  logic [BW-1:0] r_bit;
  logic [HW-1:0] r_half;
  logic [9:0]    r_raddr;
  logic          r_sck;
  logic          r_sdo;
  logic          r_cs_n;
  logic          r_busy;
  logic          r_done;
  logic          w_half_end;

  assign w_half_end = (r_half == LAST_HALF);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_shift <= '0;
      r_bit   <= '0;
      r_half  <= '0;
      r_raddr <= '0;
      r_sck   <= 1'b0;
      r_sdo   <= 1'b0;
      r_cs_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      // abort beats everything outside IDLE, including a pending half-period end
      if (abort && r_state != S_IDLE) begin
        r_state <= S_IDLE;
        r_bit   <= '0;
        r_half  <= '0;
        r_raddr <= '0;
        r_sck   <= 1'b0;
        r_sdo   <= 1'b0;
        r_cs_n  <= 1'b1;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start && !abort) begin
              r_state <= S_FETCH;
              r_bit   <= '0;
              r_half  <= '0;
              r_raddr <= '0;
              r_cs_n  <= 1'b0;
              r_busy  <= 1'b1;
            end
          end
          S_FETCH: begin
            r_shift <= rpix;
            r_sdo   <= rpix[0];
            r_half  <= '0;
            r_state <= S_LOW;
          end
          S_LOW: begin
            if (w_half_end) begin
              r_half  <= '0;
              r_sck   <= 1'b1;
              r_state <= S_HIGH;
            end else begin
              r_half <= r_half + 1'b1;
            end
          end
          S_HIGH: begin
            if (w_half_end) begin
              r_half <= '0;
              r_sck  <= 1'b0;
              if (r_bit != LAST_BIT) begin
                r_bit   <= r_bit + 1'b1;
                r_shift <= r_shift >> 1;
                r_sdo   <= r_shift[1];
                r_state <= S_LOW;
              end else if (r_raddr != LAST_PIX) begin
                r_raddr <= r_raddr + 1'b1;
                r_bit   <= '0;
                r_state <= S_FETCH;
              end else begin
                r_state <= S_FINISH;
              end
            end else begin
              r_half <= r_half + 1'b1;
            end
          end
          S_FINISH: begin
            if (w_half_end) begin
              r_half  <= '0;
              r_raddr <= '0;
              r_sdo   <= 1'b0;
              r_cs_n  <= 1'b1;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end else begin
              r_half <= r_half + 1'b1;
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign raddr = r_raddr;
  assign sck   = r_sck;
  assign sdo   = r_sdo;
  assign cs_n  = r_cs_n;
  assign busy  = r_busy;
  assign done  = r_done;
endmodule
